// File: rtl/reg_bank_ctx_8088_pkg.sv
// Shared definitions for the 8088 register bank: register index map,
// default geometry and the context save/restore sequencer states.
package pkg_8088;

   localparam int DATA_W_DEF   = 16;
   localparam int NUM_REGS_DEF = 16;
   localparam int ADDR_W_DEF   = 4;
   localparam int SP_STEP_DEF  = 2;

   // General registers in 8086 encoding order, followed by the first segment register.
   localparam int IDX_AX = 0;
   localparam int IDX_CX = 1;
   localparam int IDX_DX = 2;
   localparam int IDX_BX = 3;
   localparam int IDX_SP = 4;
   localparam int IDX_BP = 5;
   localparam int IDX_SI = 6;
   localparam int IDX_DI = 7;
   localparam int IDX_ES = 8;

   localparam int SP_IDX_DEF = IDX_SP;

   typedef enum logic [1:0] {
      CTX_IDLE    = 2'd0,
      CTX_SAVE    = 2'd1,
      CTX_RESTORE = 2'd2,
      CTX_DONE    = 2'd3
   } ctx_state_e;

endpackage

// File: rtl/reg_bank_ctx_8088_byte_lane_merge.sv
// Merges new write data into an old register word: whole-word replace or a
// single byte lane, with the byte always taken from the low lane of new_i.
module byte_lane_merge #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] old_i,
   input  logic [DATA_W-1:0] new_i,
   input  logic              size_i,
   input  logic              hi_i,
   output logic [DATA_W-1:0] merged_o
);

   localparam int H = DATA_W / 2;

   always_comb begin
      merged_o = old_i;
      if (size_i) begin
         merged_o = new_i;
      end else if (hi_i) begin
         merged_o = {new_i[H-1:0], old_i[H-1:0]};
      end else begin
         merged_o = {old_i[DATA_W-1:H], new_i[H-1:0]};
      end
   end

endmodule

// File: rtl/reg_bank_ctx_8088.sv
// 8088 register bank: byte-lane write-back with read bypass, SP push/pop
// stepper, and a save/restore sequencer streaming every register for interrupts.
module reg_bank_ctx_8088
   import pkg_8088::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int SP_IDX   = SP_IDX_DEF,
   parameter int SP_STEP  = SP_STEP_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_size,
   input  logic              wr_hi,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   input  logic              rd_size,
   input  logic              rd_hi1,
   input  logic              rd_hi2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              sp_push,
   input  logic              sp_pop,
   output logic [DATA_W-1:0] sp_out,
   input  logic              ctx_save,
   input  logic              ctx_restore,
   output logic              ctx_busy,
   output logic              so_valid,
   input  logic              so_ready,
   output logic [ADDR_W-1:0] so_idx,
   output logic [DATA_W-1:0] so_data,
   input  logic              ri_valid,
   output logic              ri_ready,
   input  logic [DATA_W-1:0] ri_data,
   output logic              ctx_done,
   output logic [1:0]        ctx_state_o
);

   localparam int H = DATA_W / 2;
   localparam logic [ADDR_W-1:0] SP_A     = ADDR_W'(SP_IDX);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
   localparam logic [DATA_W-1:0] STEP     = DATA_W'(SP_STEP);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   ctx_state_e        state_q, state_d;
   logic [ADDR_W-1:0] k_q, k_d;

   logic [DATA_W-1:0] wr_merged;
   logic [DATA_W-1:0] sp_next;
   logic [DATA_W-1:0] src1, src2;
   logic              wr_take;
   logic              sp_step;
   logic              restore_we;

   assign ctx_busy    = (state_q != CTX_IDLE);
   assign ctx_state_o = state_q;
   assign sp_out      = regs_q[SP_A];

   // One merge serves both the register update and the same-cycle read bypass.
   byte_lane_merge #(.DATA_W(DATA_W)) u_wr_merge (
      .old_i    (regs_q[wr_addr]),
      .new_i    (wr_data),
      .size_i   (wr_size),
      .hi_i     (wr_hi),
      .merged_o (wr_merged)
   );

   assign wr_take = wr_en && !ctx_busy;
   // A write-back to SP in the same cycle overrides any push/pop.
   assign sp_step = (sp_push ^ sp_pop) && !ctx_busy && !(wr_en && (wr_addr == SP_A));
   assign sp_next = sp_push ? (sp_out - STEP) : (sp_out + STEP);

   assign src1 = (wr_take && (wr_addr == rd_addr1)) ? wr_merged : regs_q[rd_addr1];
   assign src2 = (wr_take && (wr_addr == rd_addr2)) ? wr_merged : regs_q[rd_addr2];

   always_comb begin
      rd_data1 = src1;
      rd_data2 = src2;
      if (!rd_size) begin
         rd_data1 = rd_hi1 ? DATA_W'(src1[DATA_W-1:H]) : DATA_W'(src1[H-1:0]);
         rd_data2 = rd_hi2 ? DATA_W'(src2[DATA_W-1:H]) : DATA_W'(src2[H-1:0]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (restore_we) begin
         regs_q[k_q] <= ri_data;
      end else if (!ctx_busy) begin
         if (wr_en) begin
            regs_q[wr_addr] <= wr_merged;
         end
         if (sp_step) begin
            regs_q[SP_A] <= sp_next;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CTX_IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // Handshakes: a beat happens in any cycle where valid and ready are both high;
   // the producer holds its payload stable until that beat.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      so_valid   = 1'b0;
      so_idx     = '0;
      so_data    = '0;
      ri_ready   = 1'b0;
      ctx_done   = 1'b0;
      restore_we = 1'b0;
      case (state_q)
         CTX_IDLE: begin
            k_d = '0;
            if (ctx_save) begin
               state_d = CTX_SAVE;
            end else if (ctx_restore) begin
               state_d = CTX_RESTORE;
            end
         end
         CTX_SAVE: begin
            so_valid = 1'b1;
            so_idx   = k_q;
            so_data  = regs_q[k_q];
            if (so_ready) begin
               k_d = k_q + 1'b1;
               if (k_q == LAST_IDX) begin
                  state_d = CTX_DONE;
                  k_d     = '0;
               end
            end
         end
         CTX_RESTORE: begin
            ri_ready = 1'b1;
            if (ri_valid) begin
               restore_we = 1'b1;
               k_d        = k_q + 1'b1;
               if (k_q == LAST_IDX) begin
                  state_d = CTX_DONE;
                  k_d     = '0;
               end
            end
         end
         CTX_DONE: begin
            ctx_done = 1'b1;
            state_d  = CTX_IDLE;
         end
         default: state_d = CTX_IDLE;
      endcase
   end

endmodule
